// File: rtl/vnu_acc_ctrl.sv
// Variable-node accumulator: sums one channel LLR and DEG check messages (sign-magnitude in),
// then presents the symmetrically saturated two's-complement total with a hard decision.
module vnu_acc_ctrl #(
  parameter int unsigned W   = 6,
  parameter int unsigned DEG = 3,
  parameter int unsigned OW  = 7
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic [W-1:0]  i_llr,
  input  logic          i_llr_valid,
  output logic          o_llr_ready,
  input  logic [W-1:0]  i_msg,
  input  logic          i_msg_valid,
  output logic          o_msg_ready,
  output logic [OW-1:0] o_sum,
  output logic          o_hard,
  output logic          o_sum_valid,
  input  logic          i_sum_ready,
  output logic          o_busy
);

  localparam int unsigned AW     = W + 3;
  localparam int unsigned CW     = 3;
  localparam int          SatMax = (1 << (OW - 1)) - 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]        sum_q, sum_d;
  logic                 hard_q, hard_d;

  logic signed [AW-1:0] acc_sum;
  logic signed [31:0]   acc_ext;
  logic [OW-1:0]        sat_sum;

  // Negative zero maps to 0 because -0 == 0 in two's complement.
  function automatic logic signed [AW-1:0] conv(input logic [W-1:0] x);
    logic signed [AW-1:0] mag;
    mag = {{(AW - W + 1){1'b0}}, x[W-2:0]};
    return x[W-1] ? -mag : mag;
  endfunction

  always_comb begin
    acc_sum = acc_q + conv(i_msg);
    acc_ext = 32'(acc_sum);
    if (acc_ext > SatMax) begin
      sat_sum = OW'(SatMax);
    end else if (acc_ext < -SatMax) begin
      sat_sum = OW'(-SatMax);
    end else begin
      sat_sum = acc_ext[OW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    hard_d  = hard_q;
    if (i_flush) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_llr_valid) begin
            acc_d   = conv(i_llr);
            cnt_d   = '0;
            state_d = StAcc;
          end
        end
        StAcc: begin
          if (i_msg_valid) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DEG - 1)) begin
              state_d = StOut;
              sum_d   = sat_sum;
              hard_d  = sat_sum[OW-1];
            end
          end
        end
        StOut: begin
          if (i_sum_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      hard_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      hard_q  <= hard_d;
    end
  end

  // Handshake outputs decode from state only.
  assign o_llr_ready = (state_q == StIdle);
  assign o_msg_ready = (state_q == StAcc);
  assign o_sum_valid = (state_q == StOut);
  assign o_busy      = (state_q != StIdle);
  assign o_sum       = sum_q;
  assign o_hard      = hard_q;

endmodule

// File: tb/tb_vnu_acc_ctrl.sv
// Directed bench for vnu_acc_ctrl (W=6, DEG=3, OW=7) with an expected-result queue.
module tb_vnu_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] llr = '0;
  logic       llr_valid = 1'b0;
  logic       llr_ready;
  logic [5:0] msg = '0;
  logic       msg_valid = 1'b0;
  logic       msg_ready;
  logic [6:0] sum;
  logic       hard;
  logic       sum_valid;
  logic       sum_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  vnu_acc_ctrl #(.W(6), .DEG(3), .OW(7)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_llr       (llr),
    .i_llr_valid (llr_valid),
    .o_llr_ready (llr_ready),
    .i_msg       (msg),
    .i_msg_valid (msg_valid),
    .o_msg_ready (msg_ready),
    .o_sum       (sum),
    .o_hard      (hard),
    .o_sum_valid (sum_valid),
    .i_sum_ready (sum_ready),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sm2int(input logic [5:0] x);
    int m;
    m = int'(x[4:0]);
    return x[5] ? -m : m;
  endfunction

  function automatic int sat63(input int v);
    if (v > 63) return 63;
    if (v < -63) return -63;
    return v;
  endfunction

  // Runs one node up to OUT and compares the result against the queued expectation.
  task automatic run_node(input string tag, input logic [5:0] l, input logic [5:0] m0,
                          input logic [5:0] m1, input logic [5:0] m2, input int gap);
    logic [5:0] m[3];
    int exp_sum;
    int got;
    m[0] = m0; m[1] = m1; m[2] = m2;
    check({tag, "_llr_ready"}, int'(llr_ready), 1);
    exp_q.push_back(sat63(sm2int(l) + sm2int(m0) + sm2int(m1) + sm2int(m2)));
    llr = l; llr_valid = 1'b1;
    tick();
    llr_valid = 1'b0;
    check({tag, "_msg_ready"}, int'(msg_ready), 1);
    for (int k = 0; k < 3; k++) begin
      msg = m[k]; msg_valid = 1'b1;
      tick();
      msg_valid = 1'b0;
      if (k < 2) repeat (gap) tick();
    end
    check({tag, "_valid_latency"}, int'(sum_valid), 1);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      exp_sum = exp_q.pop_front();
      got = int'($signed(sum));
      check({tag, "_sum"}, got, exp_sum);
      check({tag, "_hard"}, int'(hard), (exp_sum < 0) ? 1 : 0);
    end
  endtask

  task automatic release_out(input string tag);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check({tag, "_back_idle"}, int'({busy, llr_ready, sum_valid}), 3'b010);
  endtask

  initial begin
    int held;
    int cyc;
    // Reset state.
    #2;
    check("rst_outputs", int'({sum, hard, sum_valid, msg_ready, llr_ready, busy}),
          {7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tick();
    rst_n = 1'b1;
    tick();

    // Messages in IDLE are ignored.
    msg = 6'b000111; msg_valid = 1'b1;
    tick(); tick();
    msg_valid = 1'b0;
    check("idle_msg_ignored", int'({busy, llr_ready}), 2'b01);

    run_node("nominal", 6'b001010, 6'b000011, 6'b100101, 6'b100000, 0);
    release_out("nominal");

    run_node("sat_pos", 6'b011111, 6'b011111, 6'b011111, 6'b011111, 0);
    release_out("sat_pos");
    run_node("sat_neg", 6'b111111, 6'b111111, 6'b111111, 6'b111111, 0);

    // Backpressure: stray valids must not disturb a waiting result.
    held = int'($signed(sum));
    msg_valid = 1'b1; llr_valid = 1'b1; sum_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sum_stable", int'($signed(sum)), held);
      check("bp_readys", int'({sum_valid, llr_ready, msg_ready}), 3'b100);
    end
    msg_valid = 1'b0;
    sum_ready = 1'b1;
    tick();
    llr_valid = 1'b0; sum_ready = 1'b0;
    check("bp_release", int'({busy, llr_ready}), 2'b01);

    run_node("gapped", 6'b001010, 6'b000011, 6'b100101, 6'b100000, 2);
    release_out("gapped");

    // Flush after one message overrides a simultaneous message handshake.
    llr = 6'b000001; llr_valid = 1'b1;
    tick();
    llr_valid = 1'b0;
    msg = 6'b000001; msg_valid = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; msg_valid = 1'b0;
    check("flush_idle", int'({busy, llr_ready, msg_ready}), 3'b010);
    run_node("post_flush", 6'b000001, 6'b000001, 6'b000001, 6'b000001, 0);

    // Asynchronous reset while in OUT, then the nominal node again.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", int'({sum, hard, sum_valid, msg_ready, llr_ready, busy}),
          {7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tick();
    rst_n = 1'b1;
    tick();
    run_node("post_rst", 6'b001010, 6'b000011, 6'b100101, 6'b100000, 0);

    // Bounded wait for IDLE after release.
    sum_ready = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (busy && cyc < 10);
    sum_ready = 1'b0;
    check("final_idle_cycles", cyc, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
